// File: rtl/btn_step_pkg.sv
// Shared types and constants for the btn_step_ctrl push-button conditioner.
package btn_step_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } step_state_t;

  // Default timing for a 12 MHz clock: 20 ms debounce, 0.5 s repeat delay, 100 ms rate.
  localparam int DEF_DEBOUNCE_CYCLES = 240000;
  localparam int DEF_REPEAT_DELAY    = 6000000;
  localparam int DEF_REPEAT_RATE     = 1200000;

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_DEBOUNCE_CYCLES, DEF_REPEAT_DELAY, DEF_REPEAT_RATE);

endpackage

// File: rtl/btn_step_channel.sv
// One button channel: 2-flop sync, debounce, step FSM, combinational pulse request.
// AUTO_REPEAT_EN adds the hold counter and REPEAT state.
module btn_step_channel
  import btn_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic lock,
  output logic stable,
  output logic pulse_req
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] db_cnt;
  step_state_t   st, st_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
      st     <= IDLE;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
      st <= st_nxt;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  logic [CW-1:0] hcnt, hcnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hcnt <= '0;
    else     hcnt <= hcnt_nxt;
  end
`endif

  // Lock and release take priority over any pending pulse.
  always_comb begin
    st_nxt    = st;
    pulse_req = 1'b0;
`ifdef AUTO_REPEAT_EN
    hcnt_nxt  = '0;
`endif
    case (st)
      IDLE: begin
        if (lock) begin
          st_nxt = LOCK;
        end else if (stable) begin
          pulse_req = 1'b1;
          st_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (lock)         st_nxt = LOCK;
        else if (!stable) st_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
        else if (hcnt == DLY_LAST) begin
          pulse_req = 1'b1;
          st_nxt    = REPEAT;
        end else begin
          hcnt_nxt = hcnt + CW'(1);
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      REPEAT: begin
        if (lock)         st_nxt = LOCK;
        else if (!stable) st_nxt = IDLE;
        else if (hcnt == RATE_LAST) begin
          pulse_req = 1'b1;
        end else begin
          hcnt_nxt = hcnt + CW'(1);
        end
      end
`endif
      LOCK: begin
        if (!lock) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/btn_step_ctrl.sv
// Two-button step-pulse generator for adjustable_pwm: two channels, LOCK arbitration,
// registered mutually exclusive outputs. Optional hold-to-repeat via AUTO_REPEAT_EN.
module btn_step_ctrl
  import btn_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_cycle_up,
  output logic o_cycle_down
);

  logic [1:0] btn, stable, req;
  logic       lock_q, lock;

  assign btn  = {i_btn_down, i_btn_up};
  // Lock asserts as soon as both are held and releases only once both are released.
  assign lock = (&stable) | lock_q;

  btn_step_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_ch [1:0] (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .lock     (lock),
    .stable   (stable),
    .pulse_req(req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q       <= 1'b0;
      o_cycle_up   <= 1'b0;
      o_cycle_down <= 1'b0;
    end else begin
      if (&stable)       lock_q <= 1'b1;
      else if (~|stable) lock_q <= 1'b0;
      o_cycle_up   <= req[0] & ~req[1];
      o_cycle_down <= req[1] & ~req[0];
    end
  end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
module tb_btn_step_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic o_up, o_down;
  int   total = 0;
  int   bad = 0;

  btn_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_up    (btn_up),
    .i_btn_down  (btn_down),
    .o_cycle_up  (o_up),
    .o_cycle_down(o_down)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_up = 1'b0;
    btn_down = 1'b0;
    for (int i = 0; i < 20; i++) step();
  endtask

  task automatic test_reset();
    int nu, nd;
    nu = 0; nd = 0;
    #1;
    total++;
    if (o_up !== 1'b0 || o_down !== 1'b0) begin
      bad++; $display("FAIL reset_init got=%b%b exp=00", o_up, o_down);
    end
    for (int i = 0; i < 10; i++) begin
      btn_up = i[0];
      btn_down = ~i[0];
      step();
      total++;
      if (o_up !== 1'b0 || o_down !== 1'b0) begin
        bad++; $display("FAIL reset_held cyc=%0d got=%b%b exp=00", i, o_up, o_down);
      end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (o_up === 1'b1) nu++;
      if (o_down === 1'b1) nd++;
    end
    total++;
    if (nu != 0 || nd != 0) begin
      bad++; $display("FAIL reset_idle got up=%0d dn=%0d exp=0/0", nu, nd);
    end
  endtask

  task automatic test_clean_press();
    int nu, nd, at;
    nu = 0; nd = 0; at = -1;
    for (int i = 1; i <= 30; i++) begin
      btn_up = (i <= 10);
      step();
      if (o_up === 1'b1) begin nu++; at = i; end
      if (o_down === 1'b1) nd++;
    end
    total++;
    if (nu != 1) begin bad++; $display("FAIL clean_count got=%0d exp=1", nu); end
    total++;
    if (at != 7) begin bad++; $display("FAIL clean_time got=%0d exp=7", at); end
    total++;
    if (nd != 0) begin bad++; $display("FAIL clean_down got=%0d exp=0", nd); end
  endtask

  task automatic test_bounce();
    int nu, nd, at;
    nu = 0; nd = 0; at = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 20) btn_down = (((i - 1) / 2) % 2 == 0);
      else         btn_down = (i <= 30);
      step();
      if (o_down === 1'b1) begin nd++; at = i; end
      if (o_up === 1'b1) nu++;
    end
    total++;
    if (nd != 1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", nd); end
    total++;
    if (at != 27) begin bad++; $display("FAIL bounce_time got=%0d exp=27", at); end
    total++;
    if (nu != 0) begin bad++; $display("FAIL bounce_up got=%0d exp=0", nu); end
  endtask

  task automatic test_auto_repeat();
    int q[$];
    int exp[$];
`ifdef AUTO_REPEAT_EN
    exp = '{7, 27, 35, 43, 51, 59};
`else
    exp = '{7};
`endif
    for (int i = 1; i <= 90; i++) begin
      btn_up = (i <= 60);
      step();
      if (o_up === 1'b1) q.push_back(i);
    end
    total++;
    if (q.size() != exp.size()) begin
      bad++; $display("FAIL repeat_count got=%0d exp=%0d", q.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        total++;
        if (q[k] != exp[k]) begin
          bad++; $display("FAIL repeat_time idx=%0d got=%0d exp=%0d", k, q[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int q[$];
    int exp[$];
    int nd;
    nd = 0;
`ifdef AUTO_REPEAT_EN
    exp = '{7, 27, 35, 106};
`else
    exp = '{7, 106};
`endif
    for (int i = 1; i <= 130; i++) begin
      btn_up   = (i <= 80) || (i >= 100 && i <= 110);
      btn_down = (i >= 31 && i <= 50);
      step();
      if (o_up === 1'b1) q.push_back(i);
      if (o_down === 1'b1) nd++;
      total++;
      if ((o_up & o_down) !== 1'b0) begin
        bad++; $display("FAIL sim_invariant cyc=%0d got=%b%b exp=not 11", i, o_up, o_down);
      end
    end
    total++;
    if (nd != 0) begin bad++; $display("FAIL sim_down got=%0d exp=0", nd); end
    total++;
    if (q.size() != exp.size()) begin
      bad++; $display("FAIL sim_up_count got=%0d exp=%0d", q.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        total++;
        if (q[k] != exp[k]) begin
          bad++; $display("FAIL sim_up_time idx=%0d got=%0d exp=%0d", k, q[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int pre, nu, at;
    logic last;
    pre = 0; nu = 0; at = -1; last = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      btn_up = 1'b1;
      step();
      if (o_up === 1'b1) pre++;
      last = o_up;
    end
    total++;
`ifdef AUTO_REPEAT_EN
    if (pre != 3 || last !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%0d/%b exp=3/1", pre, last);
    end
`else
    if (pre != 1 || last !== 1'b0) begin
      bad++; $display("FAIL midrst_pre got=%0d/%b exp=1/0", pre, last);
    end
`endif
    rst = 1'b1;
    #1;
    total++;
    if (o_up !== 1'b0 || o_down !== 1'b0) begin
      bad++; $display("FAIL midrst_immediate got=%b%b exp=00", o_up, o_down);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (o_up !== 1'b0 || o_down !== 1'b0) begin
        bad++; $display("FAIL midrst_held got=%b%b exp=00", o_up, o_down);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      btn_up = (j <= 12);
      step();
      if (o_up === 1'b1) begin nu++; at = j; end
    end
    total++;
    if (nu != 1 || at != 7) begin
      bad++; $display("FAIL midrst_after got=%0d@%0d exp=1@7", nu, at);
    end
  endtask

  initial begin
    test_reset();
    settle();
    test_clean_press();
    settle();
    test_bounce();
    settle();
    test_auto_repeat();
    settle();
    test_simultaneous();
    settle();
    test_reset_mid_hold();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
